// File: rtl/sram_pipe.sv
// Single-clock 1R1W SRAM model with lane write enables and a fixed-latency read pipeline.
// Optional per-lane even parity is enabled by defining SRAM_PARITY_EN.
module sram_pipe #(
  parameter int WORDSIZE     = 64,
  parameter int WIDTH        = 512,
  parameter int LOGDEPTH     = 9,
  parameter int READ_LATENCY = 2,
  parameter int RDW_NEW      = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      readEn,
  input  logic [LOGDEPTH-1:0]       readAddr,
  output logic                      readValid,
  output logic [WIDTH-1:0]          readData,
  input  logic [LOGDEPTH-1:0]       writeAddr,
  input  logic [WIDTH-1:0]          writeData,
  input  logic [WIDTH/WORDSIZE-1:0] writeEnable,
  output logic                      parityErr
);

  localparam int LANES = WIDTH / WORDSIZE;
  localparam int DEPTH = 1 << LOGDEPTH;

  if (WIDTH % WORDSIZE != 0) begin : gWidthCheck
    $fatal(1, "sram_pipe: WIDTH must be a multiple of WORDSIZE");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : gLatencyCheck
    $fatal(1, "sram_pipe: READ_LATENCY must be within 1..8");
  end

  // Handshake: no ready/backpressure. readEn is a one-cycle request sampled on the
  // rising edge; readValid is a one-cycle response exactly READ_LATENCY edges later.

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [LANES-1:0]       laneWr;
  logic [LANES-1:0]       fwd;
  logic [WIDTH-1:0]       rdWord;
  logic [READ_LATENCY-1:0] pipeVld;
  logic [WIDTH-1:0]       pipeData [READ_LATENCY];

  // Writes are suppressed while reset is held; storage itself is never cleared.
  assign laneWr = writeEnable & {LANES{reset_n}};

`ifdef SRAM_PARITY_EN
  logic [LANES-1:0] parMem [DEPTH];
`endif

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (laneWr[i]) begin
        mem[writeAddr][i*WORDSIZE +: WORDSIZE] <= writeData[i*WORDSIZE +: WORDSIZE];
`ifdef SRAM_PARITY_EN
        parMem[writeAddr][i] <= ^writeData[i*WORDSIZE +: WORDSIZE];
`endif
      end
    end
  end

  // Stage-0 array read; with RDW_NEW the enabled lanes of a same-address write bypass.
  always_comb begin
    rdWord = mem[readAddr];
    fwd    = '0;
    for (int i = 0; i < LANES; i++) begin
      fwd[i] = (RDW_NEW != 0) && readEn && (readAddr == writeAddr) && laneWr[i];
      if (fwd[i]) begin
        rdWord[i*WORDSIZE +: WORDSIZE] = writeData[i*WORDSIZE +: WORDSIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipeVld <= '0;
    end else begin
      pipeVld[0] <= readEn;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipeVld[k] <= pipeVld[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (readEn) begin
      pipeData[0] <= rdWord;
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      if (pipeVld[k-1]) begin
        pipeData[k] <= pipeData[k-1];
      end
    end
  end

  // readData only moves when a response lands, so it holds the last response otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readValid <= 1'b0;
      readData  <= '0;
    end else begin
      readValid <= pipeVld[READ_LATENCY-1];
      if (pipeVld[READ_LATENCY-1]) begin
        readData <= pipeData[READ_LATENCY-1];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic                    rdErr;
  logic [READ_LATENCY-1:0] pipeErr;

  // Forwarded lanes are checked against freshly computed parity, so they never flag.
  always_comb begin
    rdErr = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if ((^rdWord[i*WORDSIZE +: WORDSIZE]) !=
          (fwd[i] ? (^writeData[i*WORDSIZE +: WORDSIZE]) : parMem[readAddr][i])) begin
        rdErr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (readEn) begin
      pipeErr[0] <= rdErr;
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      if (pipeVld[k-1]) begin
        pipeErr[k] <= pipeErr[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parityErr <= 1'b0;
    end else begin
      parityErr <= pipeVld[READ_LATENCY-1] & pipeErr[READ_LATENCY-1];
    end
  end

  // Corrupts one stored data bit without touching its parity.
  task flipBit(input logic [LOGDEPTH-1:0] addr, input int bitIdx);
    mem[addr][bitIdx] <= ~mem[addr][bitIdx];
  endtask
`else
  assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_sram_pipe.sv
// Directed bench for sram_pipe: three instances (latency 2/old, 1/new, 4/old) share stimulus;
// a negedge monitor checks valid, data, hold and parity of every instance every cycle.
module tb_sram_pipe;
  localparam int W = 512;
  localparam logic [W-1:0] P5  = {8{64'h0123456789ABCDEF}};
  localparam logic [W-1:0] Q5  = {8{64'hFEDCBA9876543210}};
  localparam logic [W-1:0] E7  = {{6{64'hAAAAAAAAAAAAAAAA}}, 64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA};
  localparam logic [W-1:0] O3  = {64{8'h11}};
  localparam logic [W-1:0] N3  = {{7{64'h1111111111111111}}, 64'h2222222222222222};

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         readEn = 1'b0;
  logic [8:0]   readAddr = '0;
  logic [8:0]   writeAddr = '0;
  logic [W-1:0] writeData = '0;
  logic [7:0]   writeEnable = '0;

  logic rvA, rvB, rvC, peA, peB, peC;
  logic [W-1:0] rdA, rdB, rdC;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  int         dueA[$], dueB[$], dueC[$];
  logic [W-1:0] exp_qA[$], exp_qB[$], exp_qC[$];
  bit         perA[$], perB[$], perC[$];
  logic [W-1:0] lastA = '0, lastB = '0, lastC = '0;

  sram_pipe dutA (
    .clk(clk), .reset_n(reset_n), .readEn(readEn), .readAddr(readAddr),
    .readValid(rvA), .readData(rdA), .writeAddr(writeAddr), .writeData(writeData),
    .writeEnable(writeEnable), .parityErr(peA)
  );

  sram_pipe #(.READ_LATENCY(1), .RDW_NEW(1)) dutB (
    .clk(clk), .reset_n(reset_n), .readEn(readEn), .readAddr(readAddr),
    .readValid(rvB), .readData(rdB), .writeAddr(writeAddr), .writeData(writeData),
    .writeEnable(writeEnable), .parityErr(peB)
  );

  sram_pipe #(.READ_LATENCY(4), .RDW_NEW(0)) dutC (
    .clk(clk), .reset_n(reset_n), .readEn(readEn), .readAddr(readAddr),
    .readValid(rvC), .readData(rdC), .writeAddr(writeAddr), .writeData(writeData),
    .writeEnable(writeEnable), .parityErr(peC)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int a);
    logic [7:0] b;
    b = a[7:0] ^ 8'h5C;
    return {64{b}};
  endfunction

  // One cycle of stimulus; expectations for a read are queued with their due cycle.
  task automatic step(input logic re, input logic [8:0] ra, input logic [7:0] we,
                      input logic [8:0] wa, input logic [W-1:0] wd,
                      input logic [W-1:0] expOld, input logic [W-1:0] expNew, input bit expPe);
    readEn = re; readAddr = ra; writeEnable = we; writeAddr = wa; writeData = wd;
    if (re) begin
      dueA.push_back(cyc + 1 + 2); exp_qA.push_back(expOld); perA.push_back(expPe);
      dueB.push_back(cyc + 1 + 1); exp_qB.push_back(expNew); perB.push_back(expPe);
      dueC.push_back(cyc + 1 + 4); exp_qC.push_back(expOld); perC.push_back(expPe);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic mon(input string tag, input logic v, input logic [W-1:0] d, input logic pe,
                     input bit now, input logic [W-1:0] expd, input bit expPe,
                     inout logic [W-1:0] last);
    chk({tag, ".valid"}, v, now);
    if (now) begin
      chk({tag, ".data"}, d, expd);
      last = expd;
    end else begin
      chk({tag, ".hold"}, d, last);
    end
    chk({tag, ".parity"}, pe, now ? expPe : 1'b0);
  endtask

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    bit nA, nB, nC;
    nA = dueA.size() > 0 && dueA[0] == cyc;
    nB = dueB.size() > 0 && dueB[0] == cyc;
    nC = dueC.size() > 0 && dueC[0] == cyc;
    mon("A", rvA, rdA, peA, nA, nA ? exp_qA[0] : '0, nA ? perA[0] : 1'b0, lastA);
    mon("B", rvB, rdB, peB, nB, nB ? exp_qB[0] : '0, nB ? perB[0] : 1'b0, lastB);
    mon("C", rvC, rdC, peC, nC, nC ? exp_qC[0] : '0, nC ? perC[0] : 1'b0, lastC);
    if (nA) begin void'(dueA.pop_front()); void'(exp_qA.pop_front()); void'(perA.pop_front()); end
    if (nB) begin void'(dueB.pop_front()); void'(exp_qB.pop_front()); void'(perB.pop_front()); end
    if (nC) begin void'(dueC.pop_front()); void'(exp_qC.pop_front()); void'(perC.pop_front()); end
  end

  task automatic chk_zero(input string tag);
    chk({tag, ".A.valid"}, rvA, 0); chk({tag, ".A.data"}, rdA, 0); chk({tag, ".A.parity"}, peA, 0);
    chk({tag, ".B.valid"}, rvB, 0); chk({tag, ".B.data"}, rdB, 0); chk({tag, ".B.parity"}, peB, 0);
    chk({tag, ".C.valid"}, rvC, 0); chk({tag, ".C.data"}, rdC, 0); chk({tag, ".C.parity"}, peC, 0);
  endtask

  initial begin
    logic [W-1:0] d9, f9, d10;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_init");
    @(negedge clk);
    reset_n = 1'b1;

    // back-to-back: fill 0..15, then read them on consecutive cycles while writing elsewhere
    for (int a = 0; a < 16; a++) step(1'b0, '0, 8'hFF, 9'(a), pat(a), '0, '0, 1'b0);
    for (int a = 0; a < 16; a++) step(1'b1, 9'(a), 8'hFF, 9'(a + 32), pat(a + 32), pat(a), pat(a), 1'b0);
    idle(6);

    // basic latency, then a write behind an in-flight read
    step(1'b0, '0, 8'hFF, 9'd5, P5, '0, '0, 1'b0);
    step(1'b1, 9'd5, 8'h00, '0, '0, P5, P5, 1'b0);
    step(1'b0, '0, 8'hFF, 9'd5, Q5, '0, '0, 1'b0);
    idle(5);
    step(1'b1, 9'd5, 8'h00, '0, '0, Q5, Q5, 1'b0);
    idle(5);

    // partial lane write
    step(1'b0, '0, 8'hFF, 9'd7, {64{8'hAA}}, '0, '0, 1'b0);
    step(1'b0, '0, 8'h02, 9'd7, {64{8'h55}}, '0, '0, 1'b0);
    step(1'b1, 9'd7, 8'h00, '0, '0, E7, E7, 1'b0);
    idle(5);

    // same-address read during a lane-0 write
    step(1'b0, '0, 8'hFF, 9'd3, O3, '0, '0, 1'b0);
    step(1'b1, 9'd3, 8'h01, 9'd3, {64{8'h22}}, O3, N3, 1'b0);
    step(1'b1, 9'd3, 8'h00, '0, '0, N3, N3, 1'b0);
    idle(6);

    // reset mid-flight, with a write attempted while reset is held
    step(1'b1, 9'd5, 8'h00, '0, '0, Q5, Q5, 1'b0);
    step(1'b1, 9'd7, 8'h00, '0, '0, E7, E7, 1'b0);
    step(1'b1, 9'd3, 8'h00, '0, '0, N3, N3, 1'b0);
    reset_n = 1'b0;
    dueA.delete(); exp_qA.delete(); perA.delete(); lastA = '0;
    dueB.delete(); exp_qB.delete(); perB.delete(); lastB = '0;
    dueC.delete(); exp_qC.delete(); perC.delete(); lastC = '0;
    #1;
    chk_zero("reset_mid");
    readEn = 1'b1; readAddr = 9'd5; writeEnable = 8'hFF; writeAddr = 9'd5; writeData = '1;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    readEn = 1'b0; writeEnable = 8'h00;
    idle(6);
    step(1'b1, 9'd5, 8'h00, '0, '0, Q5, Q5, 1'b0);
    step(1'b1, 9'd7, 8'h00, '0, '0, E7, E7, 1'b0);
    step(1'b1, 9'd3, 8'h00, '0, '0, N3, N3, 1'b0);
    idle(6);

`ifdef SRAM_PARITY_EN
    d9  = {64{8'h3C}};
    d10 = {64{8'hC3}};
    f9  = d9;
    f9[70] = ~f9[70];
    step(1'b0, '0, 8'hFF, 9'd9, d9, '0, '0, 1'b0);
    step(1'b0, '0, 8'hFF, 9'd10, d10, '0, '0, 1'b0);
    dutA.flipBit(9'd9, 70);
    dutB.flipBit(9'd9, 70);
    dutC.flipBit(9'd9, 70);
    step(1'b1, 9'd9, 8'h00, '0, '0, f9, f9, 1'b1);
    step(1'b1, 9'd10, 8'h00, '0, '0, d10, d10, 1'b0);
    idle(6);
`else
    d9 = '0; f9 = '0; d10 = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
